raymarch_frame_sequencer: RTL and testbench

- Frame-level controller wrapped around the raymarcher pipeline.
- Upstream: issues one pixel coordinate per cycle and presents a frame-stable camera (look-at matrix + eye), double-buffered from HPS writes.
- Downstream: carries a valid/address tag through a delay line matched to raymarcher latency, and turns the returned RGB into framebuffer write strobes.
- The raymarcher is free-running with no stall, so this block owns all frame timing.

---
 rtl/raymarch_frame_sequencer_pkg.sv | 43 ++++
 rtl/raymarch_frame_sequencer_if.sv | 40 ++++
 rtl/raymarch_frame_sequencer_tag_delay_line.sv | 30 +++
 rtl/raymarch_frame_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_raymarch_frame_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/raymarch_frame_sequencer_pkg.sv
// Shared constants, camera register map and sequencer state encoding for the
// raymarch frame sequencer and its testbench-visible interface.
package raymarch_pkg;

    localparam int H_RES_DEF = 640;
    localparam int V_RES_DEF = 480;
    localparam int FB_AW     = 19;
    localparam int FP_W      = 27;

    localparam logic [FP_W-1:0] FP_ONE  = 27'h1fc0000;
    localparam logic [FP_W-1:0] FP_ZERO = 27'h0000000;
    localparam logic [FP_W-1:0] FP_FIVE = 27'h2050000;

    typedef enum logic [3:0] {
        LA11, LA12, LA13,
        LA21, LA22, LA23,
        LA31, LA32, LA33,
        EYE_X, EYE_Y, EYE_Z,
        CAM_N
    } cam_idx_e;

    localparam int CAM_REGS = int'(CAM_N);
    localparam int CAM_W    = CAM_REGS * FP_W;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } seq_state_e;

    // Camera power-up value: identity look-at, eye parked at z = 5.0.
    function automatic logic [FP_W-1:0] cam_reset_value(input int idx);
        logic [FP_W-1:0] value;
        value = FP_ZERO;
        if (idx == int'(LA11) || idx == int'(LA22) || idx == int'(LA33)) begin
            value = FP_ONE;
        end else if (idx == int'(EYE_Z)) begin
            value = FP_FIVE;
        end
        return value;
    endfunction

endpackage

// File: rtl/raymarch_frame_sequencer_if.sv
// Bus bundle between the frame sequencer (master) and the raymarcher,
// camera register writer and framebuffer (slave side).
interface raymarch_frame_sequencer_if
    import raymarch_pkg::*;
#(
    parameter int CORDW = 10
);

    logic              cam_wr_en;
    logic [3:0]        cam_wr_addr;
    logic [FP_W-1:0]   cam_wr_data;
    logic              cam_commit;

    logic [CORDW-1:0]  pixel_x;
    logic [CORDW-1:0]  pixel_y;
    logic [CAM_W-1:0]  cam_active;

    logic [7:0]        red;
    logic [7:0]        green;
    logic [7:0]        blue;

    logic              fb_we;
    logic [FB_AW-1:0]  fb_addr;
    logic [23:0]       fb_data;

    modport master (
        input  cam_wr_en, cam_wr_addr, cam_wr_data, cam_commit,
        input  red, green, blue,
        output pixel_x, pixel_y, cam_active,
        output fb_we, fb_addr, fb_data
    );

    modport slave (
        output cam_wr_en, cam_wr_addr, cam_wr_data, cam_commit,
        output red, green, blue,
        input  pixel_x, pixel_y, cam_active,
        input  fb_we, fb_addr, fb_data
    );

endinterface

// File: rtl/raymarch_frame_sequencer_tag_delay_line.sv
// Fixed-depth shift register that carries the pixel tag alongside the
// raymarcher pipeline; asynchronous clear drops every in-flight tag.
module tag_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] tag_i,
    output logic [WIDTH-1:0] tag_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/raymarch_frame_sequencer.sv
// Frame timing owner for the free-running raymarcher: pixel scan, camera
// double-buffering and latency-matched framebuffer strobes.
// Optional SCAN_TEST_PATTERN_EN adds test_pat, replacing colour with {x,y,80}.
module raymarch_frame_sequencer
    import raymarch_pkg::*;
#(
    parameter int H_RES        = H_RES_DEF,
    parameter int V_RES        = V_RES_DEF,
    parameter int PIPE_LATENCY = 180,
    parameter int CORDW        = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_en,
`ifdef SCAN_TEST_PATTERN_EN
    input  logic test_pat,
`endif
    raymarch_frame_sequencer_if.master bus,
    output logic busy,
    output logic frame_done
);

    localparam int DCW = (PIPE_LATENCY > 1) ? $clog2(PIPE_LATENCY) : 1;
    localparam logic [CORDW-1:0] X_LAST     = CORDW'(H_RES - 1);
    localparam logic [CORDW-1:0] Y_LAST     = CORDW'(V_RES - 1);
    localparam logic [DCW-1:0]   DRAIN_LAST = DCW'(PIPE_LATENCY - 1);
`ifdef SCAN_TEST_PATTERN_EN
    localparam int TAG_W = 1 + FB_AW + 16;
`else
    localparam int TAG_W = 1 + FB_AW;
`endif

    seq_state_e       state_q, state_d;
    logic [CORDW-1:0] x_q, x_d;
    logic [CORDW-1:0] y_q, y_d;
    logic [FB_AW-1:0] addr_q, addr_d;
    logic [DCW-1:0]   drain_cnt_q, drain_cnt_d;
    logic             pending_q, pending_d;
    logic             frame_start;
    logic             drain_last;

    logic [FP_W-1:0]  shadow_q [CAM_REGS];
    logic [FP_W-1:0]  active_q [CAM_REGS];

    logic [TAG_W-1:0] tag_in;
    logic [TAG_W-1:0] tag_out;
    logic             tag_valid;
    logic [FB_AW-1:0] tag_addr;

    logic             fb_we_q;
    logic [FB_AW-1:0] fb_addr_q;
    logic [23:0]      fb_data_q, fb_data_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            addr_q      <= '0;
            drain_cnt_q <= '0;
            pending_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            addr_q      <= addr_d;
            drain_cnt_q <= drain_cnt_d;
            pending_q   <= pending_d;
        end
    end

    // The framebuffer address advances alongside x/y so no y*H_RES product is needed.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        addr_d      = addr_q;
        drain_cnt_d = drain_cnt_q;
        frame_start = 1'b0;
        drain_last  = (state_q == DRAIN) && (drain_cnt_q == DRAIN_LAST);

        case (state_q)
            IDLE: begin
                if (run_en) begin
                    frame_start = 1'b1;
                end
            end
            RUN: begin
                if (x_q == X_LAST) begin
                    if (y_q == Y_LAST) begin
                        state_d     = DRAIN;
                        drain_cnt_d = '0;
                    end else begin
                        x_d    = '0;
                        y_d    = y_q + 1'b1;
                        addr_d = addr_q + 1'b1;
                    end
                end else begin
                    x_d    = x_q + 1'b1;
                    addr_d = addr_q + 1'b1;
                end
            end
            DRAIN: begin
                drain_cnt_d = drain_cnt_q + 1'b1;
                if (drain_last) begin
                    if (run_en) begin
                        frame_start = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (frame_start) begin
            state_d = RUN;
            x_d     = '0;
            y_d     = '0;
            addr_d  = '0;
        end
    end

    // A commit landing on the frame-start edge survives to the following frame.
    always_comb begin
        pending_d = pending_q | bus.cam_commit;
        if (frame_start) begin
            pending_d = bus.cam_commit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < CAM_REGS; k++) begin
                shadow_q[k] <= cam_reset_value(k);
                active_q[k] <= cam_reset_value(k);
            end
        end else begin
            if (frame_start && pending_q) begin
                for (int k = 0; k < CAM_REGS; k++) begin
                    active_q[k] <= shadow_q[k];
                end
            end
            if (bus.cam_wr_en && (bus.cam_wr_addr < 4'(CAM_REGS))) begin
                shadow_q[bus.cam_wr_addr] <= bus.cam_wr_data;
            end
        end
    end

    for (genvar k = 0; k < CAM_REGS; k++) begin : g_cam_pack
        assign bus.cam_active[k*FP_W +: FP_W] = active_q[k];
    end

`ifdef SCAN_TEST_PATTERN_EN
    assign tag_in = {state_q == RUN, addr_q, x_q[7:0], y_q[7:0]};
`else
    assign tag_in = {state_q == RUN, addr_q};
`endif

    tag_delay_line #(
        .WIDTH (TAG_W),
        .DEPTH (PIPE_LATENCY)
    ) u_tag_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

    assign tag_valid = tag_out[TAG_W-1];
    assign tag_addr  = tag_out[TAG_W-2 -: FB_AW];

    always_comb begin
        fb_data_d = {bus.red, bus.green, bus.blue};
`ifdef SCAN_TEST_PATTERN_EN
        if (test_pat) begin
            fb_data_d = {tag_out[15:8], tag_out[7:0], 8'h80};
        end
`endif
    end

    // Colour arrives with the delayed tag, so one shared register stage keeps all three aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fb_we_q   <= 1'b0;
            fb_addr_q <= '0;
            fb_data_q <= '0;
        end else begin
            fb_we_q   <= tag_valid;
            fb_addr_q <= tag_addr;
            fb_data_q <= fb_data_d;
        end
    end

    assign bus.pixel_x = x_q;
    assign bus.pixel_y = y_q;
    assign bus.fb_we   = fb_we_q;
    assign bus.fb_addr = fb_addr_q;
    assign bus.fb_data = fb_data_q;
    assign busy        = (state_q != IDLE);
    assign frame_done  = drain_last;

endmodule

// File: tb/tb_raymarch_frame_sequencer.sv
// Self-checking bench: an ideal 4-cycle raymarcher plus a cycle-indexed
// timeline of expected strobes, busy, frame_done and camera contents.
module tb_raymarch_frame_sequencer;

    localparam int H    = 8;
    localparam int V    = 2;
    localparam int L    = 4;
    localparam int CW   = 10;
    localparam int N    = H * V;
    localparam int MAXC = 1024;

    logic clk;
    logic rst_n;
    logic run_en;
    logic test_pat;
    logic busy;
    logic frame_done;

    raymarch_frame_sequencer_if #(.CORDW(CW)) bus ();

    raymarch_frame_sequencer #(
        .H_RES        (H),
        .V_RES        (V),
        .PIPE_LATENCY (L),
        .CORDW        (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run_en     (run_en),
`ifdef SCAN_TEST_PATTERN_EN
        .test_pat   (test_pat),
`endif
        .bus        (bus),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors;
    int checks;
    int cyc;
    int frameEnd;
    int seenStrobes;

    bit          expWe   [MAXC];
    bit          expBusy [MAXC];
    bit          expDone [MAXC];
    int          expAddr [MAXC];
    int          expPx   [MAXC];
    int          expPy   [MAXC];
    logic [23:0] expData [MAXC];

    logic [26:0] mShadow [12];
    logic [26:0] mActive [12];
    bit          mPending;

    logic [7:0]  gtab [N];
    logic [7:0]  btab [N];
    int          hx [5];
    int          hy [5];

    function automatic logic [26:0] camInit(input int k);
        if (k == 0 || k == 4 || k == 8) return 27'h1fc0000;
        if (k == 11) return 27'h2050000;
        return 27'h0;
    endfunction

    function automatic logic [323:0] packCam();
        logic [323:0] v;
        v = '0;
        for (int k = 0; k < 12; k++) v[k*27 +: 27] = mActive[k];
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [323:0] observed, input logic [323:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
        end
    endtask

    task automatic resetModel();
        for (int k = 0; k < 12; k++) begin
            mShadow[k] = camInit(k);
            mActive[k] = camInit(k);
        end
        mPending = 1'b0;
        frameEnd = -1;
        for (int c = cyc; c < MAXC; c++) begin
            expWe[c]   = 1'b0;
            expBusy[c] = 1'b0;
            expDone[c] = 1'b0;
        end
    endtask

    task automatic scheduleFrame(input int s);
        for (int i = 0; i < N; i++) begin
            expBusy[s+i]     = 1'b1;
            expPx[s+i]       = i % H;
            expPy[s+i]       = i / H;
            expWe[s+L+1+i]   = 1'b1;
            expAddr[s+L+1+i] = i;
            expData[s+L+1+i] = test_pat ? {8'(i % H), 8'(i / H), 8'h80} : {8'(i), gtab[i], btab[i]};
        end
        for (int d = 1; d <= L; d++) begin
            expBusy[s+N-1+d] = 1'b1;
            expPx[s+N-1+d]   = H - 1;
            expPy[s+N-1+d]   = V - 1;
        end
        expDone[s+N-1+L] = 1'b1;
        frameEnd = s + N - 1 + L;
    endtask

    // Frame start: run_en seen while idle or on the last drain cycle.
    task automatic modelEdge();
        if (run_en && cyc >= frameEnd) begin
            if (mPending) begin
                for (int k = 0; k < 12; k++) mActive[k] = mShadow[k];
            end
            mPending = bus.cam_commit;
            scheduleFrame(cyc + 1);
        end else begin
            mPending = mPending | bus.cam_commit;
        end
        if (bus.cam_wr_en && bus.cam_wr_addr < 4'd12) mShadow[bus.cam_wr_addr] = bus.cam_wr_data;
    endtask

    task automatic checkCycle();
        checkOutput("fb_we", 324'(bus.fb_we), 324'(expWe[cyc]));
        if (bus.fb_we) seenStrobes++;
        if (expWe[cyc]) begin
            checkOutput("fb_addr", 324'(bus.fb_addr), 324'(expAddr[cyc]));
            checkOutput("fb_data", 324'(bus.fb_data), 324'(expData[cyc]));
        end
        checkOutput("busy", 324'(busy), 324'(expBusy[cyc]));
        checkOutput("frame_done", 324'(frame_done), 324'(expDone[cyc]));
        if (expBusy[cyc]) begin
            checkOutput("pixel_x", 324'(bus.pixel_x), 324'(expPx[cyc]));
            checkOutput("pixel_y", 324'(bus.pixel_y), 324'(expPy[cyc]));
        end
        checkOutput("cam_active", bus.cam_active, packCam());
    endtask

    // Ideal raymarcher: colour for a pixel appears exactly L cycles after its coordinate.
    task automatic updateRaymarcher();
        int a;
        for (int k = 4; k > 0; k--) begin
            hx[k] = hx[k-1];
            hy[k] = hy[k-1];
        end
        hx[0] = int'(bus.pixel_x);
        hy[0] = int'(bus.pixel_y);
        a = (hy[4] * H + hx[4]) % N;
        bus.red   = 8'(a);
        bus.green = gtab[a];
        bus.blue  = btab[a];
    endtask

    task automatic applyStimulus();
        if (cyc >= MAXC - 32) begin
            errors++;
            $display("[TB] FAIL cycle_budget observed=%0d required<%0d", cyc, MAXC - 32);
            $fatal(1, "[TB] cycle budget exhausted");
        end
        if (rst_n) modelEdge();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        bus.cam_wr_en  = 1'b0;
        bus.cam_commit = 1'b0;
        checkCycle();
        updateRaymarcher();
    endtask

    task automatic runUntil(input int target);
        while (cyc < target) applyStimulus();
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_pixel_x"}, 324'(bus.pixel_x), 324'(0));
        checkOutput({tag, "_pixel_y"}, 324'(bus.pixel_y), 324'(0));
        checkOutput({tag, "_fb_we"}, 324'(bus.fb_we), 324'(0));
        checkOutput({tag, "_fb_addr"}, 324'(bus.fb_addr), 324'(0));
        checkOutput({tag, "_fb_data"}, 324'(bus.fb_data), 324'(0));
        checkOutput({tag, "_busy"}, 324'(busy), 324'(0));
        checkOutput({tag, "_frame_done"}, 324'(frame_done), 324'(0));
        checkOutput({tag, "_cam_active"}, bus.cam_active, packCam());
    endtask

    task automatic randomWrite(input bit lookAtOnly);
        int r;
        r = lookAtOnly ? $urandom_range(0, 12) : $urandom_range(0, 15);
        if (lookAtOnly && r >= 9) r = r + 3;
        bus.cam_wr_en   = 1'b1;
        bus.cam_wr_addr = 4'(r);
        bus.cam_wr_data = 27'($urandom);
    endtask

    initial begin
        int s;
        int snap;
        errors      = 0;
        checks      = 0;
        cyc         = 0;
        seenStrobes = 0;
        run_en      = 1'b0;
        test_pat    = 1'b0;
        bus.cam_wr_en   = 1'b0;
        bus.cam_wr_addr = 4'd0;
        bus.cam_wr_data = 27'd0;
        bus.cam_commit  = 1'b0;
        bus.red   = 8'd0;
        bus.green = 8'd0;
        bus.blue  = 8'd0;
        for (int k = 0; k < 5; k++) begin
            hx[k] = 0;
            hy[k] = 0;
        end
        for (int k = 0; k < N; k++) begin
            gtab[k] = 8'($urandom);
            btab[k] = 8'($urandom);
        end

        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        resetModel();
        checkResetValues("por");
        @(negedge clk);
        rst_n = 1'b1;

        repeat (3) applyStimulus();

        $display("[TB] single frame, mid-frame eye_x commit");
        snap = seenStrobes;
        run_en = 1'b1;
        applyStimulus();
        run_en = 1'b0;
        s = cyc;
        repeat (3) begin
            randomWrite(1'b1);
            applyStimulus();
        end
        bus.cam_wr_en   = 1'b1;
        bus.cam_wr_addr = 4'd9;
        bus.cam_wr_data = 27'h1fc0000;
        applyStimulus();
        checkOutput("we_before_latency", 324'(bus.fb_we), 324'(0));
        bus.cam_commit = 1'b1;
        applyStimulus();
        checkOutput("first_we", 324'(bus.fb_we), 324'(1));
        checkOutput("first_addr", 324'(bus.fb_addr), 324'(0));
        runUntil(s + N - 1 + L);
        checkOutput("frame_done_at_end", 324'(frame_done), 324'(1));
        runUntil(frameEnd + L + 3);
        checkOutput("frame1_strobes", 324'(seenStrobes - snap), 324'(N));
        checkOutput("eye_x_held", 324'(bus.cam_active[269:243]), 324'(27'h0));

        $display("[TB] back-to-back frames, commit on frame-start cycle");
        run_en = 1'b1;
        applyStimulus();
        checkOutput("eye_x_applied", 324'(bus.cam_active[269:243]), 324'(27'h1fc0000));
        repeat (3) applyStimulus();
        bus.cam_wr_en   = 1'b1;
        bus.cam_wr_addr = 4'd10;
        bus.cam_wr_data = 27'h0123456;
        applyStimulus();
        runUntil(frameEnd);
        bus.cam_commit = 1'b1;
        applyStimulus();
        checkOutput("eye_y_deferred", 324'(bus.cam_active[296:270]), 324'(27'h0));
        runUntil(frameEnd);
        applyStimulus();
        checkOutput("eye_y_applied", 324'(bus.cam_active[296:270]), 324'(27'h0123456));
        run_en = 1'b0;
        runUntil(frameEnd + L + 3);

        $display("[TB] randomized run_en and camera traffic");
        for (int i = 0; i < 160; i++) begin
            run_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 4) == 0) randomWrite(1'b0);
            bus.cam_commit = ($urandom_range(0, 12) == 0);
            applyStimulus();
        end
        run_en = 1'b0;
        runUntil(frameEnd + L + 3);

`ifdef SCAN_TEST_PATTERN_EN
        $display("[TB] scan test pattern frame");
        test_pat = 1'b1;
        run_en = 1'b1;
        applyStimulus();
        run_en = 1'b0;
        s = cyc;
        runUntil(s + L + 1 + 11);
        checkOutput("pattern_x3_y1", 324'(bus.fb_data), 324'(24'h030180));
        runUntil(frameEnd + L + 3);
        test_pat = 1'b0;
`endif

        $display("[TB] reset at pixel 10");
        run_en = 1'b1;
        applyStimulus();
        run_en = 1'b0;
        s = cyc;
        runUntil(s + 10);
        #2 rst_n = 1'b0;
        #1;
        resetModel();
        checkResetValues("midframe");
        snap = seenStrobes;
        repeat (2) applyStimulus();
        rst_n = 1'b1;
        repeat (30) applyStimulus();
        checkOutput("strobes_after_reset", 324'(seenStrobes - snap), 324'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
